// File: rtl/alu_rs_scheduler_pkg.sv
// Shared definitions for the ALU reservation station.
//   ROB_W     width of a ROB id (tag) used by dispatch, CDBs and issue
//   RS_SIZE   default number of station entries (power of two, 2..16)
//   RS_IDX_W  log2(RS_SIZE)
//   OP_W      width of the {funct7[5], funct3, opcode} ALU op encoding
//   rs_entry_t  per-entry state held by the station
package alu_rs_scheduler_pkg;

  localparam int ROB_W    = 4;
  localparam int RS_SIZE  = 8;
  localparam int RS_IDX_W = 3;
  localparam int OP_W     = 11;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic             q1_busy;
    logic [ROB_W-1:0] q1;
    logic [31:0]      v1;
    logic             q2_busy;
    logic [ROB_W-1:0] q2;
    logic [31:0]      v2;
    logic [31:0]      pc;
    logic             is_short;
    logic [31:0]      imm;
    logic [ROB_W-1:0] rob_id;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_scheduler_pick.sv
// Lowest-index priority encoder.
//   vec_i    request vector, bit i set means entry i qualifies
//   found_o  at least one bit of vec_i is set
//   idx_o    index of the lowest set bit (0 when found_o is 0)
module rs_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Reservation station and issue scheduler for the single integer ALU.
// Holds dispatched ALU ops until both operands are known, snoops the ALU and
// LSB result buses for missing operands, and issues at most one ready op per
// cycle to the ALU. Flushed by the ROB on a mispredict.
//   clk_in, rst_n_in              clock; asynchronous active-low reset
//   flush_in                      synchronous flush of every entry
//   in_*                          dispatch bundle (in_valid is the strobe)
//   full                          no free entry (registered)
//   alu_cdb_*, lsb_cdb_*          result broadcasts {valid, rob_id, value}
//   alu_yes, alu_*                issue bundle to the ALU (registered)
//
// Handshakes: a dispatch is taken on a clock edge where in_valid=1, full=0 and
// flush_in=0; in_valid while full is dropped without effect. On the issue side
// alu_yes=1 for one cycle per issued op and the ALU accepts unconditionally;
// alu_* data hold their last value while alu_yes=0.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE  = alu_rs_scheduler_pkg::RS_SIZE,
  parameter int RS_IDX_W = alu_rs_scheduler_pkg::RS_IDX_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_q1_busy,
  input  logic [ROB_W-1:0] in_q1,
  input  logic [31:0]      in_v1,
  input  logic             in_q2_busy,
  input  logic [ROB_W-1:0] in_q2,
  input  logic [31:0]      in_v2,
  input  logic [31:0]      in_pc,
  input  logic             in_is_short,
  input  logic [31:0]      in_imm,
  input  logic [ROB_W-1:0] in_rob_id,
  output logic             full,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob_id,
  input  logic [31:0]      alu_cdb_value,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob_id,
  input  logic [31:0]      lsb_cdb_value,
  output logic             alu_yes,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_v1,
  output logic [31:0]      alu_v2,
  output logic [31:0]      alu_pc,
  output logic             alu_is_short,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_rob_id
);

  localparam int CNT_W = RS_IDX_W + 1;

  rs_entry_t ent_q [RS_SIZE];
  rs_entry_t ent_d [RS_SIZE];
  rs_entry_t new_ent;

  logic [CNT_W-1:0]    count_q, count_d;
  logic                alu_yes_q;
  rs_entry_t           issue_q;

  logic [RS_SIZE-1:0]  free_vec, ready_vec;
  logic                free_found, issue_found;
  logic [RS_IDX_W-1:0] free_idx, issue_idx;
  logic                do_disp, do_issue;

  // Both searches look only at registered state: a slot freed by this cycle's
  // issue is not visible to dispatch until the next cycle.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = !ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && !ent_q[i].q1_busy && !ent_q[i].q2_busy;
    end
  end

  rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_pick (
    .vec_i   (free_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_pick (
    .vec_i   (ready_vec),
    .found_o (issue_found),
    .idx_o   (issue_idx)
  );

  assign full     = (count_q == CNT_W'(RS_SIZE));
  assign do_disp  = in_valid && !full && !flush_in && free_found;
  assign do_issue = issue_found && !flush_in;

  // Incoming entry, with same-cycle CDB bypass so a tag broadcast while the
  // op is being dispatched is not missed. ALU CDB takes priority on a tie.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.op       = in_op;
    new_ent.q1_busy  = in_q1_busy;
    new_ent.q1       = in_q1;
    new_ent.v1       = in_v1;
    new_ent.q2_busy  = in_q2_busy;
    new_ent.q2       = in_q2;
    new_ent.v2       = in_v2;
    new_ent.pc       = in_pc;
    new_ent.is_short = in_is_short;
    new_ent.imm      = in_imm;
    new_ent.rob_id   = in_rob_id;
    if (in_q1_busy) begin
      if (alu_cdb_valid && alu_cdb_rob_id == in_q1) begin
        new_ent.q1_busy = 1'b0;
        new_ent.v1      = alu_cdb_value;
      end else if (lsb_cdb_valid && lsb_cdb_rob_id == in_q1) begin
        new_ent.q1_busy = 1'b0;
        new_ent.v1      = lsb_cdb_value;
      end
    end
    if (in_q2_busy) begin
      if (alu_cdb_valid && alu_cdb_rob_id == in_q2) begin
        new_ent.q2_busy = 1'b0;
        new_ent.v2      = alu_cdb_value;
      end else if (lsb_cdb_valid && lsb_cdb_rob_id == in_q2) begin
        new_ent.q2_busy = 1'b0;
        new_ent.v2      = lsb_cdb_value;
      end
    end
  end

  // Entry next-state: wakeup, then issue frees its slot, then dispatch fills
  // the free slot (never the issuing one), and flush overrides everything.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].valid && ent_q[i].q1_busy) begin
        if (alu_cdb_valid && alu_cdb_rob_id == ent_q[i].q1) begin
          ent_d[i].q1_busy = 1'b0;
          ent_d[i].v1      = alu_cdb_value;
        end else if (lsb_cdb_valid && lsb_cdb_rob_id == ent_q[i].q1) begin
          ent_d[i].q1_busy = 1'b0;
          ent_d[i].v1      = lsb_cdb_value;
        end
      end
      if (ent_q[i].valid && ent_q[i].q2_busy) begin
        if (alu_cdb_valid && alu_cdb_rob_id == ent_q[i].q2) begin
          ent_d[i].q2_busy = 1'b0;
          ent_d[i].v2      = alu_cdb_value;
        end else if (lsb_cdb_valid && lsb_cdb_rob_id == ent_q[i].q2) begin
          ent_d[i].q2_busy = 1'b0;
          ent_d[i].v2      = lsb_cdb_value;
        end
      end
    end
    if (do_issue) ent_d[issue_idx].valid = 1'b0;
    if (do_disp)  ent_d[free_idx]        = new_ent;
    if (flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_in) begin
      count_d = '0;
    end else begin
      case ({do_disp, do_issue})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      count_q   <= '0;
      alu_yes_q <= 1'b0;
      issue_q   <= '0;
    end else begin
      // Both CDBs carrying the same tag means two producers for one ROB id.
      if (alu_cdb_valid && lsb_cdb_valid)
        assert (alu_cdb_rob_id != lsb_cdb_rob_id);
      ent_q     <= ent_d;
      count_q   <= count_d;
      alu_yes_q <= do_issue;
      if (do_issue) issue_q <= ent_q[issue_idx];
    end
  end

  assign alu_yes      = alu_yes_q;
  assign alu_op       = issue_q.op;
  assign alu_v1       = issue_q.v1;
  assign alu_v2       = issue_q.v2;
  assign alu_pc       = issue_q.pc;
  assign alu_is_short = issue_q.is_short;
  assign alu_imm      = issue_q.imm;
  assign alu_rob_id   = issue_q.rob_id;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             flush, in_valid, in_q1_busy, in_q2_busy, in_is_short;
  logic [OP_W-1:0]  in_op;
  logic [ROB_W-1:0] in_q1, in_q2, in_rob_id;
  logic [31:0]      in_v1, in_v2, in_pc, in_imm;
  logic             full;
  logic             alu_cdb_valid, lsb_cdb_valid;
  logic [ROB_W-1:0] alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0]      alu_cdb_value, lsb_cdb_value;
  logic             alu_yes, alu_is_short;
  logic [OP_W-1:0]  alu_op;
  logic [31:0]      alu_v1, alu_v2, alu_pc, alu_imm;
  logic [ROB_W-1:0] alu_rob_id;

  int n_checks = 0;
  int n_pass   = 0;

  alu_rs_scheduler dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .flush_in       (flush),
    .in_valid       (in_valid),
    .in_op          (in_op),
    .in_q1_busy     (in_q1_busy),
    .in_q1          (in_q1),
    .in_v1          (in_v1),
    .in_q2_busy     (in_q2_busy),
    .in_q2          (in_q2),
    .in_v2          (in_v2),
    .in_pc          (in_pc),
    .in_is_short    (in_is_short),
    .in_imm         (in_imm),
    .in_rob_id      (in_rob_id),
    .full           (full),
    .alu_cdb_valid  (alu_cdb_valid),
    .alu_cdb_rob_id (alu_cdb_rob_id),
    .alu_cdb_value  (alu_cdb_value),
    .lsb_cdb_valid  (lsb_cdb_valid),
    .lsb_cdb_rob_id (lsb_cdb_rob_id),
    .lsb_cdb_value  (lsb_cdb_value),
    .alu_yes        (alu_yes),
    .alu_op         (alu_op),
    .alu_v1         (alu_v1),
    .alu_v2         (alu_v2),
    .alu_pc         (alu_pc),
    .alu_is_short   (alu_is_short),
    .alu_imm        (alu_imm),
    .alu_rob_id     (alu_rob_id)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_is_short   = 1'b0;
    alu_cdb_valid = 1'b0;
    lsb_cdb_valid = 1'b0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op,
                      input logic q1b, input logic [ROB_W-1:0] q1, input logic [31:0] v1,
                      input logic q2b, input logic [ROB_W-1:0] q2, input logic [31:0] v2,
                      input logic [31:0] imm, input logic [ROB_W-1:0] rob);
    in_valid   = 1'b1;
    in_op      = op;
    in_q1_busy = q1b;
    in_q1      = q1;
    in_v1      = v1;
    in_q2_busy = q2b;
    in_q2      = q2;
    in_v2      = v2;
    in_imm     = imm;
    in_rob_id  = rob;
    in_pc      = 32'h1000 + 32'(rob) * 4;
  endtask

  task automatic acdb(input logic [ROB_W-1:0] rob, input logic [31:0] val);
    alu_cdb_valid  = 1'b1;
    alu_cdb_rob_id = rob;
    alu_cdb_value  = val;
  endtask

  task automatic lcdb(input logic [ROB_W-1:0] rob, input logic [31:0] val);
    lsb_cdb_valid  = 1'b1;
    lsb_cdb_rob_id = rob;
    lsb_cdb_value  = val;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    clr();
    in_op = '0; in_q1_busy = 0; in_q1 = '0; in_v1 = '0; in_q2_busy = 0;
    in_q2 = '0; in_v2 = '0; in_pc = '0; in_imm = '0; in_rob_id = '0;
    alu_cdb_rob_id = '0; alu_cdb_value = '0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
    step();
    step();
    check("rst_yes",  alu_yes, 0);
    check("rst_full", full, 0);
    check("rst_v1",   alu_v1, 0);
    check("rst_rob",  alu_rob_id, 0);
    rst_n = 1'b1;

    // Ready ADDI: alu_yes two cycles after the dispatch cycle.
    disp(11'h013, 0, 0, 32'd5, 0, 0, 32'd0, 32'd7, 4'd1);
    step(); clr();
    check("addi_c1_yes", alu_yes, 0);
    step();
    check("addi_yes", alu_yes, 1);
    check("addi_v1",  alu_v1, 5);
    check("addi_imm", alu_imm, 7);
    check("addi_rob", alu_rob_id, 1);
    check("addi_op",  alu_op, 11'h013);
    check("addi_pc",  alu_pc, 32'h1004);
    step();
    check("addi_after_yes", alu_yes, 0);
    check("addi_hold_v1",   alu_v1, 5);

    // ADD waiting on tag 3, woken by the ALU CDB in cycle 4, issued in cycle 6.
    disp(11'h033, 1, 4'd3, 32'd0, 0, 0, 32'd2, 32'd0, 4'd4);
    step(); clr();
    step(); step();
    check("add_wait_yes", alu_yes, 0);
    acdb(4'd3, 32'h10);
    step(); clr();
    check("add_c5_yes", alu_yes, 0);
    step();
    check("add_yes", alu_yes, 1);
    check("add_v1",  alu_v1, 32'h10);
    check("add_v2",  alu_v2, 2);
    check("add_rob", alu_rob_id, 4);
    step();

    // SUB whose tag-2 operand is broadcast by the LSB CDB in the dispatch cycle.
    disp(11'h433, 0, 0, 32'd1, 1, 4'd2, 32'd0, 32'd0, 4'd5);
    in_is_short = 1'b1;
    lcdb(4'd2, 32'hAB);
    step(); clr();
    check("byp_c1_yes", alu_yes, 0);
    step();
    check("byp_yes",   alu_yes, 1);
    check("byp_v2",    alu_v2, 32'hAB);
    check("byp_v1",    alu_v1, 1);
    check("byp_rob",   alu_rob_id, 5);
    check("byp_op",    alu_op, 11'h433);
    check("byp_short", alu_is_short, 1);
    step();
    check("byp_after_yes", alu_yes, 0);

    // Fill all eight entries with ops waiting on tags 8..15 (entry i -> tag 8+i).
    for (int i = 0; i < 8; i++) begin
      disp(11'h033, 1, 4'(8 + i), 32'(i), 0, 0, 32'd0, 32'd0, 4'(i));
      step();
      check("fill_full", full, (i == 7) ? 32'd1 : 32'd0);
    end
    clr();
    // A ready ninth op while full must be dropped (it would otherwise issue).
    disp(11'h013, 0, 0, 32'h99, 0, 0, 32'd0, 32'd0, 4'd15);
    step(); step(); step(); clr();
    check("full_drop_yes",  alu_yes, 0);
    check("full_drop_full", full, 1);
    // Wake entries 1 (tag 9) and 6 (tag 14) together.
    acdb(4'd9,  32'h111);
    lcdb(4'd14, 32'h666);
    step(); clr();
    check("wake_c1_yes",  alu_yes, 0);
    check("wake_c1_full", full, 1);
    step();
    check("wake_first_yes",  alu_yes, 1);
    check("wake_first_rob",  alu_rob_id, 1);
    check("wake_first_v1",   alu_v1, 32'h111);
    check("wake_first_full", full, 0);
    step();
    check("wake_second_yes", alu_yes, 1);
    check("wake_second_rob", alu_rob_id, 6);
    check("wake_second_v1",  alu_v1, 32'h666);
    step();
    check("wake_done_yes", alu_yes, 0);

    // Issue entry 0, then reset while alu_yes is high and five entries remain.
    acdb(4'd8, 32'h888);
    step(); clr();
    step();
    check("pre_rst_yes", alu_yes, 1);
    check("pre_rst_rob", alu_rob_id, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_yes",  alu_yes, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_v1",   alu_v1, 0);
    check("mid_rst_op",   alu_op, 0);
    step(); step();
    rst_n = 1'b1;
    // Two waiting ops, woken together: the first one dispatched sits in
    // entry 0 and issues first. Stale pre-reset entries on tags 12/13 would
    // issue extra ops.
    disp(11'h013, 1, 4'd12, 32'd0, 0, 0, 32'd0, 32'd0, 4'd10);
    step();
    disp(11'h013, 1, 4'd13, 32'd0, 0, 0, 32'd0, 32'd0, 4'd11);
    step(); clr();
    acdb(4'd13, 32'h13);
    lcdb(4'd12, 32'h12);
    step(); clr();
    check("post_rst_c1_yes", alu_yes, 0);
    step();
    check("post_rst_first_yes", alu_yes, 1);
    check("post_rst_first_rob", alu_rob_id, 10);
    check("post_rst_first_v1",  alu_v1, 32'h12);
    step();
    check("post_rst_second_yes", alu_yes, 1);
    check("post_rst_second_rob", alu_rob_id, 11);
    check("post_rst_second_v1",  alu_v1, 32'h13);
    step();
    check("post_rst_idle_yes", alu_yes, 0);
    step();
    check("post_rst_idle2_yes", alu_yes, 0);

    // Flush with three ready entries and a concurrent dispatch.
    for (int i = 0; i < 3; i++) begin
      disp(11'h013, 1, 4'd1, 32'd0, 0, 0, 32'd0, 32'd0, 4'(i + 1));
      step();
    end
    clr();
    acdb(4'd1, 32'h55);
    step(); clr();
    check("flush_pre_yes", alu_yes, 0);
    flush = 1'b1;
    disp(11'h013, 0, 0, 32'h77, 0, 0, 32'd0, 32'd0, 4'd9);
    step(); clr();
    check("flush_yes", alu_yes, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush_quiet_yes", alu_yes, 0);
    end
    // Count restarted at zero: full rises exactly on the eighth dispatch.
    for (int i = 0; i < 8; i++) begin
      disp(11'h033, 1, 4'd0, 32'd0, 0, 0, 32'd0, 32'd0, 4'(i));
      step();
      check("refill_full", full, (i == 7) ? 32'd1 : 32'd0);
    end
    clr();
    step();
    check("refill_idle_yes", alu_yes, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
